imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Drives the core's instruction-memory write port (I_WE/I_WD) from a byte stream.
//   - Parses framed program images: sync, length, data words, checksum.
//   - Packs bytes into 32-bit little-endian words and pulses I_WE once per word.
//   - Holds the core in reset (core_rstn) while loading; releases it only after a good frame.
//   - Sits between the host byte link (e.g. a UART receiver) and the top-level I_WE/I_WD/rstn inputs.
// PARAMETERS
//   MEM_DEPTH  256   instruction memory depth in words; largest legal word count
//   SYNC       8'hA5 frame start byte
// PORTS
//   clk          in   1   system clock
//   rstn         in   1   asynchronous, active-low reset
//   in_data      in   8   stream byte
//   in_valid     in   1   in_data is valid
//   in_ready     out  1   loader accepts the byte this cycle
//   I_WE         out  1   instruction memory write enable; one-cycle pulse per word
//   I_WD         out  32  instruction word
//   core_rstn    out  1   active-low reset to the core
//   busy         out  1   a frame is in progress (LEN0..CHK)
//   done         out  1   last frame loaded and verified; core running
//   err          out  1   last frame rejected
//   word_cnt     out  16  words written in the current or last frame
// BEHAVIOUR
//   - Reset: state=SYNC, I_WE=0, I_WD=0, core_rstn=0, busy=0, done=0, err=0, word_cnt=0, in_ready=1.
//   - Handshake: a byte is consumed only when in_valid & in_ready. in_ready=1 in every state.
//   - Frame format: SYNC, N[7:0], N[15:8], 4*N data bytes (LSB first per word), CHK.
//     CHK = XOR of all 4*N data bytes.
//   - FSM:
//     - SYNC: consume bytes; SYNC -> LEN0; any other byte is discarded.
//     - LEN0: store N low byte -> LEN1.
//     - LEN1: store N high byte. N==0 or N>MEM_DEPTH -> ERR; otherwise -> DATA with byte_idx=0.
//     - DATA: shift the byte into the word register at byte_idx*8 and XOR it into the checksum.
//       On byte_idx==3: the next cycle I_WD=word and I_WE=1 for exactly one cycle; word_cnt++.
//       After word N -> CHK.
//     - CHK: byte==checksum -> RUN; otherwise -> ERR.
//     - RUN: core_rstn=1, done=1. A SYNC byte -> LEN0 (reload). Other bytes are discarded.
//     - ERR: err=1, core_rstn=0. A SYNC byte -> LEN0. Other bytes are discarded.
//   - Entering LEN0 from any state:
//     - clears word_cnt, checksum, byte_idx, done and err;
//     - drives core_rstn=0 on the next edge;
//     - core_rstn is therefore low at least 2 cycles before the first I_WE, so the fetch-side write pointer restarts at 0.
//   - core_rstn is registered and glitch-free; it rises on the cycle after the CHK byte is accepted with a match.
//   - I_WD holds its value between pulses. I_WE is never high in two consecutive cycles.
//   - busy=1 exactly in LEN0, LEN1, DATA and CHK.
//   - Stalls: in_valid low mid-word or mid-frame freezes the state. There is no timeout.
//   - rstn asserted mid-frame: immediate return to the reset values. The partial image is abandoned and core_rstn stays 0.
//   - word_cnt saturates at N. Byte and word counters are sized so that MEM_DEPTH*4 does not overflow.
// STRUCTURE
//   - Shared package: SYNC byte value, FSM state encoding (SYNC, LEN0, LEN1, DATA, CHK, RUN, ERR), frame header length.
//   - One sub-module, word_packer:
//     - byte_idx counter, 32-bit shift/assemble register, XOR checksum;
//     - produces a one-cycle word_valid.
//   - The top FSM owns length checks, core_rstn and the status outputs.
// TESTING
//   - Good frame: A5 02 00 | 13 00 10 00 | 93 00 20 00 | CHK=0xB0
//     -> I_WE pulses twice, I_WD=0x00100013 then 0x00200093, core_rstn rises after CHK, done=1, word_cnt=2.
//   - Bad checksum: same frame with CHK=0x00 -> err=1, done=0, core_rstn stays 0, two I_WE pulses already issued.
//   - Length bounds: N=0x0000 and N=0x0101 with MEM_DEPTH=256 -> ERR right after LEN1, no I_WE;
//     N=256 with valid data and checksum -> 256 pulses, done=1.
//   - Noise and stalls:
//     - 0x00 0xFF ahead of A5 are discarded;
//     - in_valid randomly deasserted inside words -> identical I_WD sequence, I_WE never in consecutive cycles.
//   - Reload while running: in RUN, send a new frame -> core_rstn low the cycle after LEN0 entry,
//     word_cnt restarts at 0, core_rstn high again after the new CHK.
//   - Reset mid-frame: rstn low after byte 5 of a frame -> all outputs at reset values;
//     a following full good frame loads correctly.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: frame constants and FSM states.
package imem_loader_pkg;

    // Frame start byte and header size (SYNC, N[7:0], N[15:8])
    localparam logic [7:0] SYNC_BYTE     = 8'hA5;
    localparam int         HDR_LEN       = 3;
    localparam int         DEF_MEM_DEPTH = 256;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CHK,
        ST_RUN,
        ST_ERR
    } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Assembles little-endian 32-bit words from data bytes, keeps the running XOR
// checksum and emits a one-cycle word_valid with the completed word.
module imem_loader_word_packer (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid,
    output logic [1:0]  o_byte_idx,
    output logic [7:0]  o_checksum
);

    logic [23:0] r_asm;
    logic [31:0] r_word;
    logic        r_word_valid;
    logic [1:0]  r_byte_idx;
    logic [7:0]  r_csum;

    // Byte assembly, checksum accumulation and the completed-word pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_asm        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_byte_idx   <= '0;
            r_csum       <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples
            // pre-edge values; the default below is overridden later in the block.
            r_word_valid <= 1'b0;
            if (i_clear) begin
                r_byte_idx <= '0;
                r_csum     <= '0;
            end else if (i_byte_valid) begin
                r_csum     <= r_csum ^ i_byte;
                r_byte_idx <= r_byte_idx + 2'd1;
                case (r_byte_idx)
                    2'd0: r_asm[7:0]   <= i_byte;
                    2'd1: r_asm[15:8]  <= i_byte;
                    2'd2: r_asm[23:16] <= i_byte;
                    2'd3: begin
                        // Word register holds its value until the next word completes
                        r_word       <= {i_byte, r_asm};
                        r_word_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;
    assign o_byte_idx   = r_byte_idx;
    assign o_checksum   = r_csum;

endmodule

// File: rtl/imem_loader.sv
// Frame parser that loads the instruction memory from a byte stream and keeps
// the core in reset until a complete, checksum-verified image has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         MEM_DEPTH = DEF_MEM_DEPTH,
    parameter logic [7:0] SYNC      = SYNC_BYTE
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        I_WE,
    output logic [31:0] I_WD,
    output logic        core_rstn,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] word_cnt
);

    localparam logic [15:0] MAX_WORDS = 16'(MEM_DEPTH);

    state_t      r_state;
    logic [15:0] r_len;
    logic [15:0] r_word_cnt;
    logic        r_core_rstn;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic        w_accept;
    logic        w_start;
    logic        w_data_byte;
    logic [15:0] w_len;
    logic [1:0]  w_byte_idx;
    logic [7:0]  w_checksum;

    // The loader never back-pressures the link
    assign in_ready    = 1'b1;
    assign w_accept    = in_valid & in_ready;
    // A SYNC byte restarts a frame from idle, from a running core or after an error
    assign w_start     = w_accept && (in_data == SYNC) &&
                         (r_state inside {ST_SYNC, ST_RUN, ST_ERR});
    assign w_data_byte = w_accept && (r_state == ST_DATA);
    assign w_len       = {in_data, r_len[7:0]};

    imem_loader_word_packer u_packer (
        .clk          (clk),
        .rstn         (rstn),
        .i_clear      (w_start),
        .i_byte_valid (w_data_byte),
        .i_byte       (in_data),
        .o_word       (I_WD),
        .o_word_valid (I_WE),
        .o_byte_idx   (w_byte_idx),
        .o_checksum   (w_checksum)
    );

    // Frame FSM: length checks, word counting, core reset and status flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_SYNC;
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_core_rstn <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_start) begin
            r_state     <= ST_LEN0;
            r_word_cnt  <= '0;
            r_core_rstn <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_accept) begin
            case (r_state)
                ST_LEN0: begin
                    r_len[7:0] <= in_data;
                    r_state    <= ST_LEN1;
                end
                ST_LEN1: begin
                    r_len[15:8] <= in_data;
                    if (w_len == 16'd0 || w_len > MAX_WORDS) begin
                        r_state <= ST_ERR;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_byte_idx == 2'd3) begin
                        if (r_word_cnt != r_len) r_word_cnt <= r_word_cnt + 16'd1;
                        if (r_word_cnt == r_len - 16'd1) r_state <= ST_CHK;
                    end
                end
                ST_CHK: begin
                    r_busy <= 1'b0;
                    if (in_data == w_checksum) begin
                        r_state     <= ST_RUN;
                        r_core_rstn <= 1'b1;
                        r_done      <= 1'b1;
                    end else begin
                        r_state <= ST_ERR;
                        r_err   <= 1'b1;
                    end
                end
                default: ; // SYNC/RUN/ERR discard everything except SYNC
            endcase
        end
    end

    assign core_rstn = r_core_rstn;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; expected words and status are
// derived from the frame contents the bench itself builds.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int DEPTH = 256;

    logic        clk      = 1'b0;
    logic        rstn     = 1'b1;
    logic [7:0]  in_data  = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        I_WE;
    logic [31:0] I_WD;
    logic        core_rstn;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] word_cnt;

    int          n_checks  = 0;
    int          n_pass    = 0;
    int          stall_pct = 0;
    int          consec    = 0;
    logic        prev_we   = 1'b0;
    logic [31:0] obs_q[$];
    logic [7:0]  tx_data[$];

    imem_loader #(.MEM_DEPTH(DEPTH), .SYNC(SYNC_BYTE)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .I_WE      (I_WE),
        .I_WD      (I_WD),
        .core_rstn (core_rstn),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    // Word-write monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (I_WE === 1'b1) begin
            obs_q.push_back(I_WD);
            if (prev_we === 1'b1) consec++;
        end
        prev_we = I_WE;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_we"},        32'(I_WE),      32'd0);
        check({pfx, "_wd"},        I_WD,           32'd0);
        check({pfx, "_core_rstn"}, 32'(core_rstn), 32'd0);
        check({pfx, "_busy"},      32'(busy),      32'd0);
        check({pfx, "_done"},      32'(done),      32'd0);
        check({pfx, "_err"},       32'(err),       32'd0);
        check({pfx, "_word_cnt"},  32'(word_cnt),  32'd0);
        check({pfx, "_in_ready"},  32'(in_ready),  32'd1);
    endtask

    // One byte, preceded by a random number of idle cycles
    task automatic send_byte(input logic [7:0] b);
        while ($urandom_range(0, 99) < stall_pct) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic fill_random(input int n);
        tx_data.delete();
        for (int i = 0; i < 4 * n; i++) tx_data.push_back(8'($urandom_range(0, 255)));
    endtask

    // Sends noise, then a frame of n words from tx_data, and checks the outcome
    task automatic send_frame(input logic [15:0] n, input bit chk_ok, input int noise);
        logic [31:0] exp_q[$];
        logic [7:0]  x;
        logic [7:0]  nb;
        bit          len_ok;
        len_ok = (n != 16'd0) && (int'(n) <= DEPTH);
        for (int i = 0; i < noise; i++) begin
            nb = 8'($urandom_range(0, 255));
            if (nb == SYNC_BYTE) nb = 8'h00;
            send_byte(nb);
        end
        obs_q.delete();
        consec = 0;
        send_byte(SYNC_BYTE);
        check("start_core_rstn", 32'(core_rstn), 32'd0);
        check("start_busy",      32'(busy),      32'd1);
        check("start_word_cnt",  32'(word_cnt),  32'd0);
        check("start_done",      32'(done),      32'd0);
        check("start_err",       32'(err),       32'd0);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        if (!len_ok) begin
            check("len_err",       32'(err),          32'd1);
            check("len_busy",      32'(busy),         32'd0);
            check("len_core_rstn", 32'(core_rstn),    32'd0);
            check("len_no_we",     32'(obs_q.size()), 32'd0);
            return;
        end
        x = 8'h00;
        for (int w = 0; w < int'(n); w++) begin
            exp_q.push_back({tx_data[4*w+3], tx_data[4*w+2], tx_data[4*w+1], tx_data[4*w]});
            for (int k = 0; k < 4; k++) x ^= tx_data[4*w+k];
        end
        for (int i = 0; i < 4 * int'(n); i++) send_byte(tx_data[i]);
        check("pre_chk_core_rstn", 32'(core_rstn), 32'd0);
        check("pre_chk_busy",      32'(busy),      32'd1);
        check("pre_chk_word_cnt",  32'(word_cnt),  32'(n));
        send_byte(chk_ok ? x : (x ^ 8'($urandom_range(1, 255))));
        check("end_done",      32'(done),          32'(chk_ok));
        check("end_err",       32'(err),           32'(!chk_ok));
        check("end_core_rstn", 32'(core_rstn),     32'(chk_ok));
        check("end_busy",      32'(busy),          32'd0);
        check("end_word_cnt",  32'(word_cnt),      32'(n));
        check("end_we_count",  32'(obs_q.size()),  32'(n));
        check("end_no_consec", 32'(consec),        32'd0);
        check("end_wd_hold",   I_WD,               exp_q[exp_q.size()-1]);
        for (int w = 0; w < int'(n) && w < obs_q.size(); w++) check("wd", obs_q[w], exp_q[w]);
    endtask

    task automatic load_spec_frame();
        tx_data = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
    endtask

    initial begin
        #2 rstn = 1'b0;
        #1 check_reset_values("rst");
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;

        // Known program with leading noise
        send_byte(8'h00);
        send_byte(8'hFF);
        load_spec_frame();
        send_frame(16'd2, 1'b1, 0);
        check("spec_w0", (obs_q.size() > 0) ? obs_q[0] : 32'hDEAD_BEEF, 32'h0010_0013);
        check("spec_w1", (obs_q.size() > 1) ? obs_q[1] : 32'hDEAD_BEEF, 32'h0020_0093);

        // Reload from RUN with a bad checksum, then recover from ERR
        load_spec_frame();
        send_frame(16'd2, 1'b0, 0);
        load_spec_frame();
        send_frame(16'd2, 1'b1, 2);

        // Length bounds
        send_frame(16'h0000, 1'b1, 0);
        send_frame(16'h0101, 1'b1, 1);
        fill_random(DEPTH);
        send_frame(16'(DEPTH), 1'b1, 0);

        // Random frames with stalls and noise
        for (int it = 0; it < 12; it++) begin
            int n;
            n         = $urandom_range(1, 8);
            stall_pct = $urandom_range(0, 60);
            fill_random(n);
            send_frame(16'(n), ($urandom_range(0, 3) != 0), $urandom_range(0, 3));
        end

        // Reset in the middle of a frame, then a full load
        stall_pct = 0;
        send_byte(SYNC_BYTE);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        rstn = 1'b0;
        #2 check_reset_values("midrst");
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        check_reset_values("postrst");
        stall_pct = 30;
        load_spec_frame();
        send_frame(16'd2, 1'b1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
